// File: rtl/ifft8_stream.sv
// 8-point radix-2 DIT inverse FFT over a valid/ready sample stream, one butterfly stage per cycle.
// Define IFFT_SCALE_EN for a per-stage >>>1 (true 1/8 IDFT); undefined gives the unscaled 8*IDFT.

module ifft8_bfly #(
  parameter int DW      = 16,
  parameter int TW_FRAC = 8
) (
  input  logic [1:0]           tw_i,
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  output logic signed [DW-1:0] p_re_o,
  output logic signed [DW-1:0] p_im_o,
  output logic signed [DW-1:0] q_re_o,
  output logic signed [DW-1:0] q_im_o
);
  localparam int PW = DW + 10;
  localparam int SW = DW + 2;
  localparam logic signed [PW-1:0] C45 = PW'(181);
  localparam logic signed [PW-1:0] DIV = PW'(2 ** TW_FRAC);

  logic signed [PW-1:0] wr, wi, br, bi, cr, ci;
  logic signed [DW:0]   wb_re, wb_im;
  logic signed [SW-1:0] sp_re, sp_im, sm_re, sm_im;

  // tw_i: 0 -> 1, 1 -> (1+j)/sqrt2, 2 -> +j, 3 -> (-1+j)/sqrt2
  always_comb begin
    br = PW'(b_re_i);
    bi = PW'(b_im_i);
    wr = '0;
    wi = '0;
    if (tw_i == 2'd1) begin wr = C45;  wi = C45; end
    if (tw_i == 2'd3) begin wr = -C45; wi = C45; end
    cr = wr * br - wi * bi;
    ci = wr * bi + wi * br;
    case (tw_i)
      2'd0: begin wb_re = (DW+1)'(b_re_i);    wb_im = (DW+1)'(b_im_i); end
      2'd2: begin wb_re = -((DW+1)'(b_im_i)); wb_im = (DW+1)'(b_re_i); end
      default: begin wb_re = (DW+1)'(cr / DIV); wb_im = (DW+1)'(ci / DIV); end
    endcase
    // extra headroom so a full-scale rotated term never clips before the shift
    sp_re = SW'(a_re_i) + SW'(wb_re);
    sp_im = SW'(a_im_i) + SW'(wb_im);
    sm_re = SW'(a_re_i) - SW'(wb_re);
    sm_im = SW'(a_im_i) - SW'(wb_im);
`ifdef IFFT_SCALE_EN
    p_re_o = DW'(sp_re >>> 1);
    p_im_o = DW'(sp_im >>> 1);
    q_re_o = DW'(sm_re >>> 1);
    q_im_o = DW'(sm_im >>> 1);
`else
    p_re_o = DW'(sp_re);
    p_im_o = DW'(sp_im);
    q_re_o = DW'(sm_re);
    q_im_o = DW'(sm_im);
`endif
  end
endmodule

module ifft8_stream #(
  parameter int LEN     = 8,
  parameter int DW      = 16,
  parameter int TW_FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_re,
  input  logic [DW-1:0]         in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LEN*2*DW-1:0]   dataout
);
  typedef enum logic [2:0] {LOAD, S1, S2, S3, OUT} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [LEN-1:0][DW-1:0]      re_q, re_d, im_q, im_d;
  logic [LEN/2-1:0][DW-1:0]    bp_re, bp_im, bq_re, bq_im;
  logic [LEN-1:0][2*DW-1:0]    dout_q, dout_d;
  logic                        ov_q, ov_d;

  function automatic logic [2:0] pair_a(input state_t s, input int p);
    case (s)
      S2:      pair_a = 3'((p / 2) * 4 + p % 2);
      S3:      pair_a = 3'(p);
      default: pair_a = 3'(2 * p);
    endcase
  endfunction

  function automatic logic [2:0] pair_b(input state_t s, input int p);
    case (s)
      S2:      pair_b = 3'((p / 2) * 4 + p % 2 + 2);
      S3:      pair_b = 3'(p + 4);
      default: pair_b = 3'(2 * p + 1);
    endcase
  endfunction

  function automatic logic [1:0] tw_sel(input state_t s, input int p);
    case (s)
      S2:      tw_sel = (p % 2 == 1) ? 2'd2 : 2'd0;
      S3:      tw_sel = 2'(p);
      default: tw_sel = 2'd0;
    endcase
  endfunction

  for (genvar p = 0; p < LEN/2; p++) begin : g_bf
    ifft8_bfly #(.DW(DW), .TW_FRAC(TW_FRAC)) u_bf (
      .tw_i   (tw_sel(state_q, p)),
      .a_re_i (re_q[pair_a(state_q, p)]),
      .a_im_i (im_q[pair_a(state_q, p)]),
      .b_re_i (re_q[pair_b(state_q, p)]),
      .b_im_i (im_q[pair_b(state_q, p)]),
      .p_re_o (bp_re[p]),
      .p_im_o (bp_im[p]),
      .q_re_o (bq_re[p]),
      .q_im_o (bq_im[p])
    );
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = ov_q;
  assign dataout   = dout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    re_d    = re_q;
    im_d    = im_q;
    dout_d  = dout_q;
    ov_d    = ov_q;
    case (state_q)
      LOAD: if (in_valid) begin
        re_d[{cnt_q[0], cnt_q[1], cnt_q[2]}] = in_re;
        im_d[{cnt_q[0], cnt_q[1], cnt_q[2]}] = in_im;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S1;
      end
      S1, S2, S3: begin
        for (int p = 0; p < LEN/2; p++) begin
          re_d[pair_a(state_q, p)] = bp_re[p];
          im_d[pair_a(state_q, p)] = bp_im[p];
          re_d[pair_b(state_q, p)] = bq_re[p];
          im_d[pair_b(state_q, p)] = bq_im[p];
        end
        case (state_q)
          S1:      state_d = S2;
          S2:      state_d = S3;
          default: begin
            state_d = OUT;
            ov_d    = 1'b1;
            for (int n = 0; n < LEN; n++) dout_d[n] = {re_d[n], im_d[n]};
          end
        endcase
      end
      OUT: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      re_q    <= re_d;
      im_q    <= im_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_ifft8_stream.sv
// Bench for ifft8_stream: vector table through a scoreboard, plus latency, backpressure, reset and gap sequences.
module tb_ifft8_stream;
  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0]  in_re, in_im;
  logic [255:0] dataout;

  ifft8_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid),
    .out_ready(out_ready), .dataout(dataout)
  );

  typedef struct packed {
    logic [7:0][15:0] xr, xi, er, ei;
  } vec_t;

  vec_t         vecs [4];
  logic [255:0] sb_q [$];
  int           n_tests = 0;
  int           n_fail  = 0;

`ifdef IFFT_SCALE_EN
  localparam int G = 1;
`else
  localparam int G = 8;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0][15:0] v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  function automatic logic [255:0] pack(input logic [7:0][15:0] r, input logic [7:0][15:0] i);
    logic [255:0] f;
    for (int n = 0; n < 8; n++) f[32*n +: 32] = {r[n], i[n]};
    return f;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_frame", dataout, 256'h0 ^ {256{1'b1}});
      else chk("frame", dataout, sb_q.pop_front());
    end
  end

  task automatic xfer(input logic [15:0] re, input logic [15:0] im);
    int t = 0;
    in_re = re; in_im = im; in_valid = 1'b1;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("in_ready_timeout", 256'(in_ready), 256'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0][15:0] xr, input logic [7:0][15:0] xi, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      xfer(xr[k], xi[k]);
      if (gaps && k < 7) repeat (k % 3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 256'(sb_q.size()), 256'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    logic [255:0] exp;
    vecs[0].xr = v8(800, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].xi = '0;
    vecs[0].er = v8(100*G, 100*G, 100*G, 100*G, 100*G, 100*G, 100*G, 100*G);
    vecs[0].ei = '0;
    vecs[1].xr = v8(0, 800, 0, 0, 0, 0, 0, 0);
    vecs[1].xi = '0;
`ifdef IFFT_SCALE_EN
    vecs[1].er = v8(100, 70, 0, -71, -100, -71, 0, 70);
    vecs[1].ei = v8(0, 70, 100, 70, 0, -71, -100, -71);
`else
    vecs[1].er = v8(800, 565, 0, -565, -800, -565, 0, 565);
    vecs[1].ei = v8(0, 565, 800, 565, 0, -565, -800, -565);
`endif
    vecs[2].xr = v8(80, 80, 80, 80, 80, 80, 80, 80);
    vecs[2].xi = v8(-40, -40, -40, -40, -40, -40, -40, -40);
    vecs[2].er = v8(80*G, 0, 0, 0, 0, 0, 0, 0);
    vecs[2].ei = v8(-40*G, 0, 0, 0, 0, 0, 0, 0);
    vecs[3].xr = v8(0, 0, 0, 0, 800, 0, 0, 0);
    vecs[3].xi = '0;
    vecs[3].er = v8(100*G, -100*G, 100*G, -100*G, 100*G, -100*G, 100*G, -100*G);
    vecs[3].ei = '0;

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 256'(out_valid), 256'd0);
    chk("reset_in_ready", 256'(in_ready), 256'd1);
    chk("reset_dataout", dataout, 256'd0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      sb_q.push_back(pack(vecs[v].er, vecs[v].ei));
      send_frame(vecs[v].xr, vecs[v].xi, 1'b0);
      if (v == 0) begin
        for (int i = 1; i <= 3; i++) begin
          @(posedge clk); #1;
          chk("latency_out_valid", 256'(out_valid), 256'(i == 3));
          chk("latency_in_ready", 256'(in_ready), 256'd0);
        end
      end
      drain();
    end

    // backpressure: hold the frame, junk on in_valid must be ignored
    exp = pack(vecs[1].er, vecs[1].ei);
    out_ready = 1'b0;
    sb_q.push_back(exp);
    send_frame(vecs[1].xr, vecs[1].xi, 1'b0);
    in_valid = 1'b1; in_re = 16'h1234; in_im = 16'h5678;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold", {dataout[253:0], out_valid, in_ready}, {exp[253:0], 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_released_valid", 256'(out_valid), 256'd0);
    chk("bp_released_ready", 256'(in_ready), 256'd1);
    chk("bp_dataout_kept", dataout, exp);
    chk("bp_scoreboard_empty", 256'(sb_q.size()), 256'd0);

    // reset after 5 samples of a partial frame
    for (int k = 0; k < 5; k++) xfer(16'(1000 + 37*k), 16'(-500 - 11*k));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_in_ready", 256'(in_ready), 256'd1);
    chk("midreset_out_valid", 256'(out_valid), 256'd0);
    chk("midreset_dataout", dataout, 256'd0);
    sb_q.push_back(pack(vecs[0].er, vecs[0].ei));
    send_frame(vecs[0].xr, vecs[0].xi, 1'b0);
    drain();

    // in_valid gaps during LOAD
    sb_q.push_back(pack(vecs[3].er, vecs[3].ei));
    send_frame(vecs[3].xr, vecs[3].xi, 1'b1);
    drain();
    sb_q.push_back(pack(vecs[0].er, vecs[0].ei));
    send_frame(vecs[0].xr, vecs[0].xi, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
